// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode stage.
//   - tipo/op field encodings, ALU operation codes, immediate-source tags
//   - ctrl_t: the EX-stage control bundle, and CTRL_BUBBLE (all controls off)
//   - decode_ctrl(): maps {inm, tipo, op} to a ctrl_t
// Encoding summary:
//   tipo 00 ALU    : op 00 add, 01 sub, 10 and, 11 or; inm selects the immediate
//   tipo 01 MEM    : op 00 store, 01 load, 1x colour (rgb = {1, op[0]})
//   tipo 10 BRANCH : compare by subtraction
//   tipo 11 JUMP   : writes the link register
package decode_pkg;

  localparam logic [1:0] TIPO_ALU = 2'b00;
  localparam logic [1:0] TIPO_MEM = 2'b01;
  localparam logic [1:0] TIPO_BR  = 2'b10;
  localparam logic [1:0] TIPO_JMP = 2'b11;

  localparam logic [1:0] OP_ST = 2'b00;
  localparam logic [1:0] OP_LD = 2'b01;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_B = 2'b01;
  localparam logic [1:0] IMM_J = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic       alusrc;
    logic       memwrite;
    logic       resultsrc;
    logic       branch;
    logic       jump;
    logic [2:0] alucontrol;
    logic [1:0] rgb;
    logic [1:0] immsrc;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic ctrl_t decode_ctrl(input logic inm, input logic [1:0] tipo,
                                        input logic [1:0] op);
    ctrl_t c;
    c = CTRL_BUBBLE;
    case (tipo)
      TIPO_ALU: begin
        c.regwrite = 1'b1;
        c.alusrc   = inm;
        case (op)
          2'b00:   c.alucontrol = ALU_ADD;
          2'b01:   c.alucontrol = ALU_SUB;
          2'b10:   c.alucontrol = ALU_AND;
          default: c.alucontrol = ALU_OR;
        endcase
      end
      TIPO_MEM: begin
        case (op)
          OP_ST: begin
            c.memwrite = 1'b1;
            c.alusrc   = 1'b1;
          end
          OP_LD: begin
            c.regwrite  = 1'b1;
            c.resultsrc = 1'b1;
            c.alusrc    = 1'b1;
          end
          default: c.rgb = {1'b1, op[0]};
        endcase
      end
      TIPO_BR: begin
        c.branch     = 1'b1;
        c.alucontrol = ALU_SUB;
        c.immsrc     = IMM_B;
      end
      default: begin
        c.jump     = 1'b1;
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.immsrc   = IMM_J;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile_p.sv
// regfile_p: NREG x XLEN register file, two combinational read ports, one
// write port on the rising clock edge. Register 0 is hard-wired to zero and
// contents are never reset.
// Optional macro WB_BYPASS_EN: a read of the register being written this
// cycle returns the write data; otherwise it returns the pre-write value.
// Ports:
//   clk        clock
//   ra1, ra2   read addresses      rd1, rd2   read data
//   we, wa, wd write enable / address / data
module regfile_p #(
  parameter int XLEN = 18,
  parameter int NREG = 32,
  localparam int RW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic [RW-1:0]   ra1,
  input  logic [RW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [RW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] mem_q [NREG];

  always_ff @(posedge clk) begin
    if (we && wa != '0) mem_q[wa] <= wd;
  end

  always_comb begin
    rd1 = (ra1 == '0) ? '0 : mem_q[ra1];
    rd2 = (ra2 == '0) ? '0 : mem_q[ra2];
`ifdef WB_BYPASS_EN
    if (we && wa != '0 && wa == ra1) rd1 = wd;
    if (we && wa != '0 && wa == ra2) rd2 = wd;
`endif
  end

endmodule

// File: rtl/decode_stage_p.sv
// decode_stage_p: ID stage plus ID/EX pipeline register.
//   Decodes the 33-bit D-stage instruction, reads operands from regfile_p,
//   sign-extends the immediate, detects load-use hazards (one bubble each)
//   and registers everything into EX.
// E-register priority per cycle: rst > flush_i > stall_i > hazard > load.
// Optional macro WB_BYPASS_EN: same-cycle W-to-D register bypass (see regfile_p).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   instr_d, valid_d, pc_d, pcplus4_d   D-stage instruction and PCs
//   stall_i, flush_i              external hold / redirect
//   regwrite_w, rd_w, result_w    W-stage register write
//   stall_fd_o                    load-use hazard, F and D hold
//   valid_e, *_e                  registered EX controls, operands, indices, PCs
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int XLEN = 18,
  parameter int PCW  = 9,
  parameter int NREG = 32,
  parameter int IMMW = 18,
  localparam int RW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [32:0]     instr_d,
  input  logic            valid_d,
  input  logic [PCW-1:0]  pc_d,
  input  logic [PCW-1:0]  pcplus4_d,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            regwrite_w,
  input  logic [RW-1:0]   rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic            stall_fd_o,
  output logic            valid_e,
  output logic            regwrite_e,
  output logic            alusrc_e,
  output logic            memwrite_e,
  output logic            resultsrc_e,
  output logic            branch_e,
  output logic            jump_e,
  output logic [2:0]      alucontrol_e,
  output logic [1:0]      rgb_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_e,
  output logic [RW-1:0]   rs1_e,
  output logic [RW-1:0]   rs2_e,
  output logic [RW-1:0]   rd_e,
  output logic [PCW-1:0]  pc_e,
  output logic [PCW-1:0]  pcplus4_e
);

  function automatic logic [XLEN-1:0] sext_imm(input logic signed [IMMW-1:0] raw);
    logic signed [XLEN-1:0] ext;
    ext = XLEN'(raw);
    return ext;
  endfunction

  // ---- D stage: field extraction and decode ----
  logic            inm_d;
  logic [1:0]      tipo_d;
  logic [1:0]      op_d;
  logic            store_d;
  logic [RW-1:0]   rs1_d;
  logic [RW-1:0]   rs2_d;
  logic [RW-1:0]   rd_d;
  ctrl_t           ctrl_d;
  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;
  logic [XLEN-1:0] imm_d;

  assign inm_d   = instr_d[32];
  assign tipo_d  = instr_d[31:30];
  assign op_d    = instr_d[29:28];
  assign store_d = (tipo_d == TIPO_MEM) && (op_d == OP_ST);
  assign rs1_d   = instr_d[23 +: RW];
  // Register-form stores carry the data register in the low field.
  assign rs2_d   = (!inm_d && store_d) ? instr_d[0 +: RW] : instr_d[18 +: RW];
  assign rd_d    = (store_d || inm_d) ? instr_d[18 +: RW] : instr_d[0 +: RW];
  assign ctrl_d  = decode_ctrl(inm_d, tipo_d, op_d);
  assign imm_d   = sext_imm(instr_d[IMMW-1:0]);

  regfile_p #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk (clk),
    .ra1 (rs1_d),
    .ra2 (rs2_d),
    .rd1 (rd1_d),
    .rd2 (rd2_d),
    .we  (regwrite_w),
    .wa  (rd_w),
    .wd  (result_w)
  );

  // ---- E register state ----
  logic            valid_e_q,  valid_e_d;
  ctrl_t           ctrl_e_q,   ctrl_e_d;
  logic [XLEN-1:0] rd1_e_q,    rd1_e_d;
  logic [XLEN-1:0] rd2_e_q,    rd2_e_d;
  logic [XLEN-1:0] imm_e_q,    imm_e_d;
  logic [RW-1:0]   rs1_e_q,    rs1_e_d;
  logic [RW-1:0]   rs2_e_q,    rs2_e_d;
  logic [RW-1:0]   rd_e_q,     rd_e_d;
  logic [PCW-1:0]  pc_e_q,     pc_e_d;
  logic [PCW-1:0]  pcp4_e_q,   pcp4_e_d;

  // A load in E whose destination feeds D. Once the bubble reaches E this
  // drops, so each hazard costs exactly one cycle.
  logic haz;
  assign haz = valid_e_q && ctrl_e_q.resultsrc && (rd_e_q != '0) &&
               ((rd_e_q == rs1_d) || (rd_e_q == rs2_d));

  assign stall_fd_o = haz && !flush_i;

  logic bubble;
  logic load;
  // Flush beats stall so a redirect is never lost; an invalid D slot becomes
  // a bubble so side-effect controls never appear with valid_e low.
  assign bubble = flush_i || (!stall_i && (haz || !valid_d));
  assign load   = !flush_i && !stall_i && !haz && valid_d;

  always_comb begin
    valid_e_d = valid_e_q;
    ctrl_e_d  = ctrl_e_q;
    rd1_e_d   = rd1_e_q;
    rd2_e_d   = rd2_e_q;
    imm_e_d   = imm_e_q;
    rs1_e_d   = rs1_e_q;
    rs2_e_d   = rs2_e_q;
    rd_e_d    = rd_e_q;
    pc_e_d    = pc_e_q;
    pcp4_e_d  = pcp4_e_q;
    if (bubble) begin
      valid_e_d = 1'b0;
      ctrl_e_d  = CTRL_BUBBLE;
      rd1_e_d   = '0;
      rd2_e_d   = '0;
      imm_e_d   = '0;
      rs1_e_d   = '0;
      rs2_e_d   = '0;
      rd_e_d    = '0;
      pc_e_d    = '0;
      pcp4_e_d  = '0;
    end else if (load) begin
      valid_e_d = 1'b1;
      ctrl_e_d  = ctrl_d;
      rd1_e_d   = rd1_d;
      rd2_e_d   = rd2_d;
      imm_e_d   = imm_d;
      rs1_e_d   = rs1_d;
      rs2_e_d   = rs2_d;
      rd_e_d    = rd_d;
      pc_e_d    = pc_d;
      pcp4_e_d  = pcplus4_d;
    end
  end

  // ---- D -> E boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_e_q <= 1'b0;
      ctrl_e_q  <= CTRL_BUBBLE;
      rd1_e_q   <= '0;
      rd2_e_q   <= '0;
      imm_e_q   <= '0;
      rs1_e_q   <= '0;
      rs2_e_q   <= '0;
      rd_e_q    <= '0;
      pc_e_q    <= '0;
      pcp4_e_q  <= '0;
    end else begin
      valid_e_q <= valid_e_d;
      ctrl_e_q  <= ctrl_e_d;
      rd1_e_q   <= rd1_e_d;
      rd2_e_q   <= rd2_e_d;
      imm_e_q   <= imm_e_d;
      rs1_e_q   <= rs1_e_d;
      rs2_e_q   <= rs2_e_d;
      rd_e_q    <= rd_e_d;
      pc_e_q    <= pc_e_d;
      pcp4_e_q  <= pcp4_e_d;
    end
  end

  // immsrc travels with the bundle for the EX immediate mux; not exported here.
  logic [1:0] unused_immsrc;
  assign unused_immsrc = ctrl_e_q.immsrc;

  assign valid_e      = valid_e_q;
  assign regwrite_e   = ctrl_e_q.regwrite;
  assign alusrc_e     = ctrl_e_q.alusrc;
  assign memwrite_e   = ctrl_e_q.memwrite;
  assign resultsrc_e  = ctrl_e_q.resultsrc;
  assign branch_e     = ctrl_e_q.branch;
  assign jump_e       = ctrl_e_q.jump;
  assign alucontrol_e = ctrl_e_q.alucontrol;
  assign rgb_e        = ctrl_e_q.rgb;
  assign rd1_e        = rd1_e_q;
  assign rd2_e        = rd2_e_q;
  assign imm_e        = imm_e_q;
  assign rs1_e        = rs1_e_q;
  assign rs2_e        = rs2_e_q;
  assign rd_e         = rd_e_q;
  assign pc_e         = pc_e_q;
  assign pcplus4_e    = pcp4_e_q;

endmodule

// File: tb/tb_decode_stage_p.sv
// tb_decode_stage_p: directed bench for decode_stage_p with a one-deep
// scoreboard of expected E-register contents.
module tb_decode_stage_p;

  logic        clk = 1'b0;
  logic        rst;
  logic [32:0] instr_d;
  logic        valid_d;
  logic [8:0]  pc_d, pcplus4_d;
  logic        stall_i, flush_i;
  logic        regwrite_w;
  logic [4:0]  rd_w;
  logic [17:0] result_w;
  logic        stall_fd_o, valid_e;
  logic        regwrite_e, alusrc_e, memwrite_e, resultsrc_e, branch_e, jump_e;
  logic [2:0]  alucontrol_e;
  logic [1:0]  rgb_e;
  logic [17:0] rd1_e, rd2_e, imm_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [8:0]  pc_e, pcplus4_e;

  always #5 clk = ~clk;

  decode_stage_p dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .pc_d(pc_d),
    .pcplus4_d(pcplus4_d), .stall_i(stall_i), .flush_i(flush_i),
    .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
    .stall_fd_o(stall_fd_o), .valid_e(valid_e), .regwrite_e(regwrite_e),
    .alusrc_e(alusrc_e), .memwrite_e(memwrite_e), .resultsrc_e(resultsrc_e),
    .branch_e(branch_e), .jump_e(jump_e), .alucontrol_e(alucontrol_e),
    .rgb_e(rgb_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .pc_e(pc_e), .pcplus4_e(pcplus4_e)
  );

  typedef struct packed {
    logic        valid, regwrite, alusrc, memwrite, resultsrc, branch, jump;
    logic [2:0]  aluc;
    logic [1:0]  rgb;
    logic [17:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [8:0]  pc, pc4;
  } e_t;

  int   n_chk = 0, n_pass = 0, n_fail = 0;
  e_t   sb_q[$];
  e_t   cur_e = '0;
  logic last_stall;
  logic [17:0] reg_m [32];

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic e_t obs();
    e_t o;
    o = {valid_e, regwrite_e, alusrc_e, memwrite_e, resultsrc_e, branch_e, jump_e,
         alucontrol_e, rgb_e, rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e, pc_e, pcplus4_e};
    return o;
  endfunction

  function automatic logic [32:0] mk(input logic inm, input logic [1:0] tipo,
      input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] b, input logic [17:0] lo);
    return {inm, tipo, op, rs1, b, lo};
  endfunction

  // {regwrite, alusrc, memwrite, resultsrc, branch, jump, aluc[2:0], rgb[1:0]}
  function automatic logic [10:0] ref_ctrl(input logic inm, input logic [1:0] tipo,
                                           input logic [1:0] op);
    case ({tipo, op}) inside
      4'b00??: return {1'b1, inm, 4'b0000, 1'b0, op, 2'b00};
      4'b0100: return {6'b011000, 3'b000, 2'b00};
      4'b0101: return {6'b110100, 3'b000, 2'b00};
      4'b0110: return {6'b000000, 3'b000, 2'b10};
      4'b0111: return {6'b000000, 3'b000, 2'b11};
      4'b10??: return {6'b000010, 3'b001, 2'b00};
      default: return {6'b110001, 3'b000, 2'b00};
    endcase
  endfunction

  function automatic logic [17:0] rf_read(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [17:0] wd);
    if (a == 5'd0) return '0;
`ifdef WB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return reg_m[a];
  endfunction

  task automatic step(input string tag, input logic r, input logic [32:0] ins,
      input logic v, input logic [8:0] pc, input logic st, input logic fl,
      input logic we, input logic [4:0] wa, input logic [17:0] wd);
    e_t nx, exp_e;
    logic [4:0] s1, s2, d;
    logic haz, is_st;
    rst = r; instr_d = ins; valid_d = v; pc_d = pc; pcplus4_d = pc + 9'd4;
    stall_i = st; flush_i = fl; regwrite_w = we; rd_w = wa; result_w = wd;
    is_st = (ins[31:30] == 2'b01) && (ins[29:28] == 2'b00);
    s1 = ins[27:23];
    s2 = (!ins[32] && is_st) ? ins[4:0] : ins[22:18];
    d  = (is_st || ins[32]) ? ins[22:18] : ins[4:0];
    haz = cur_e.valid && cur_e.resultsrc && cur_e.rd != 5'd0 &&
          (cur_e.rd == s1 || cur_e.rd == s2);
    #1;
    last_stall = stall_fd_o;
    if (!r) chk({tag, "_stall"}, 128'(stall_fd_o), 128'(haz && !fl));
    nx = '0;
    if (r || fl) nx = '0;
    else if (st) nx = cur_e;
    else if (!haz && v) begin
      {nx.regwrite, nx.alusrc, nx.memwrite, nx.resultsrc, nx.branch, nx.jump,
       nx.aluc, nx.rgb} = ref_ctrl(ins[32], ins[31:30], ins[29:28]);
      nx.valid = 1'b1;
      nx.rd1 = rf_read(s1, we, wa, wd);
      nx.rd2 = rf_read(s2, we, wa, wd);
      nx.imm = ins[17:0];
      nx.rs1 = s1; nx.rs2 = s2; nx.rd = d;
      nx.pc = pc; nx.pc4 = pc + 9'd4;
    end
    sb_q.push_back(nx);
    if (we && wa != 5'd0) reg_m[wa] = wd;
    @(posedge clk); #1;
    exp_e = sb_q.pop_front();
    chk(tag, 128'(obs()), 128'(exp_e));
    cur_e = exp_e;
  endtask

  initial begin
    e_t snap;
    logic [32:0] ia, ld, dep, ib, ic, sti, rd9, r0i;
    logic [17:0] r9_exp;
    rst = 1'b1; instr_d = '0; valid_d = 1'b0; pc_d = '0; pcplus4_d = '0;
    stall_i = 1'b0; flush_i = 1'b0; regwrite_w = 1'b0; rd_w = '0; result_w = '0;

    // reset with garbage inputs
    step("rst0", 1, 33'h1_DEAD_BEEF, 1, 9'h1AB, 1, 1, 1, 5'd12, 18'h2AAAA);
    step("rst1", 1, 33'h0_7531_ACE5, 1, 9'h0F3, 0, 0, 1, 5'd13, 18'h15555);
    step("post_rst", 0, 33'h0, 0, 9'h0, 0, 0, 0, 5'd0, 18'h0);
    chk("rst_stall", 128'(last_stall), 128'(1'b0));
    chk("rst_valid", 128'(valid_e), 128'(1'b0));

    for (int i = 1; i < 32; i++)
      step("init", 0, 33'h0, 0, 9'h0, 0, 0, 1, i[4:0], 18'h00100 + 18'(i));
    step("w_r3", 0, 33'h0, 0, 9'h0, 0, 0, 1, 5'd3, 18'h00005);

    // addi r4 = r3 + (-2)
    ia = mk(1, 2'b00, 2'b00, 5'd3, 5'd4, 18'h3FFFE);
    step("t2_addi", 0, ia, 1, 9'h010, 0, 0, 0, 5'd0, 18'h0);
    chk("t2_rd1", 128'(rd1_e), 128'(18'h00005));
    chk("t2_imm", 128'(imm_e), 128'(18'h3FFFE));
    chk("t2_rd", 128'(rd_e), 128'(5'd4));
    chk("t2_alusrc", 128'(alusrc_e), 128'(1'b1));
    chk("t2_valid", 128'(valid_e), 128'(1'b1));

    // load r7, then a consumer of r7
    ld  = mk(0, 2'b01, 2'b01, 5'd2, 5'd0, 18'h00007);
    dep = mk(0, 2'b00, 2'b01, 5'd7, 5'd1, 18'h00008);
    step("t3_ld", 0, ld, 1, 9'h014, 0, 0, 0, 5'd0, 18'h0);
    chk("t3_resultsrc", 128'(resultsrc_e), 128'(1'b1));
    step("t3_haz", 0, dep, 1, 9'h018, 0, 0, 0, 5'd0, 18'h0);
    chk("t3_stall_hi", 128'(last_stall), 128'(1'b1));
    chk("t3_bubble", 128'(valid_e), 128'(1'b0));
    chk("t3_bub_rw", 128'(regwrite_e), 128'(1'b0));
    step("t3_go", 0, dep, 1, 9'h018, 0, 0, 0, 5'd0, 18'h0);
    chk("t3_stall_lo", 128'(last_stall), 128'(1'b0));
    chk("t3_rs1", 128'(rs1_e), 128'(5'd7));
    chk("t3_rd1", 128'(rd1_e), 128'(18'h00107));

    // external stall holds E for three cycles
    ib = mk(1, 2'b00, 2'b10, 5'd5, 5'd6, 18'h00F0F);
    ic = mk(0, 2'b10, 2'b00, 5'd1, 5'd2, 18'h3FFF0);
    step("t4_pre", 0, ib, 1, 9'h01C, 0, 0, 0, 5'd0, 18'h0);
    snap = obs();
    for (int k = 0; k < 3; k++) begin
      step("t4_hold", 0, ic, 1, 9'h020, 1, 0, 0, 5'd0, 18'h0);
      chk("t4_snap", 128'(obs()), 128'(snap));
    end
    step("t4_rel", 0, ic, 1, 9'h020, 0, 0, 0, 5'd0, 18'h0);
    chk("t4_branch", 128'(branch_e), 128'(1'b1));
    chk("t4_pc", 128'(pc_e), 128'(9'h020));

    // flush beats stall
    sti = mk(0, 2'b01, 2'b00, 5'd2, 5'd1, 18'h00006);
    step("t5_flush", 0, sti, 1, 9'h024, 1, 1, 0, 5'd0, 18'h0);
    chk("t5_valid", 128'(valid_e), 128'(1'b0));
    chk("t5_memwrite", 128'(memwrite_e), 128'(1'b0));
    step("t5_st", 0, sti, 1, 9'h024, 0, 0, 0, 5'd0, 18'h0);
    chk("t5_st_mw", 128'(memwrite_e), 128'(1'b1));
    step("t5_inv", 0, sti, 0, 9'h028, 0, 0, 0, 5'd0, 18'h0);
    chk("t5_inv_mw", 128'(memwrite_e), 128'(1'b0));
    step("t5_ld", 0, ld, 1, 9'h02C, 0, 0, 0, 5'd0, 18'h0);
    step("t5_flhaz", 0, dep, 1, 9'h030, 0, 1, 0, 5'd0, 18'h0);
    chk("t5_flhaz_stall", 128'(last_stall), 128'(1'b0));

    // other decodes
    step("jmp", 0, mk(0, 2'b11, 2'b00, 5'd3, 5'd0, 18'h00009), 1, 9'h034, 0, 0, 0, 5'd0, 18'h0);
    chk("jmp_jump", 128'(jump_e), 128'(1'b1));
    step("rgb", 0, mk(0, 2'b01, 2'b11, 5'd0, 5'd0, 18'h00000), 1, 9'h038, 0, 0, 0, 5'd0, 18'h0);
    chk("rgb_val", 128'(rgb_e), 128'(2'b11));

    // same-cycle write/read of r9
    rd9 = mk(1, 2'b00, 2'b00, 5'd9, 5'd10, 18'h00001);
`ifdef WB_BYPASS_EN
    r9_exp = 18'h12345;
`else
    r9_exp = 18'h00109;
`endif
    step("t6_byp", 0, rd9, 1, 9'h03C, 0, 0, 1, 5'd9, 18'h12345);
    chk("t6_rd1_same", 128'(rd1_e), 128'(r9_exp));
    step("t6_after", 0, rd9, 1, 9'h040, 0, 0, 0, 5'd0, 18'h0);
    chk("t6_rd1_next", 128'(rd1_e), 128'(18'h12345));
    r0i = mk(1, 2'b00, 2'b00, 5'd0, 5'd11, 18'h00002);
    step("t6_w0", 0, r0i, 1, 9'h044, 0, 0, 1, 5'd0, 18'h3FFFF);
    chk("t6_r0_same", 128'(rd1_e), 128'(18'h0));
    step("t6_r0", 0, r0i, 1, 9'h048, 0, 0, 0, 5'd0, 18'h0);
    chk("t6_r0_next", 128'(rd1_e), 128'(18'h0));

    // reset in the middle of a hazard
    step("rh_ld", 0, ld, 1, 9'h04C, 0, 0, 0, 5'd0, 18'h0);
    step("rh_rst", 1, dep, 1, 9'h050, 0, 0, 0, 5'd0, 18'h0);
    chk("rh_valid", 128'(valid_e), 128'(1'b0));
    step("rh_post", 0, dep, 1, 9'h050, 0, 0, 0, 5'd0, 18'h0);
    chk("rh_stall", 128'(last_stall), 128'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
